jtframe_rom_rq: RTL and testbench
=================================

# jtframe_rom_rq

Read-only SDRAM request slot with a small line cache. It sits between a game-core client (CPU or graphics fetcher) and a slot arbiter such as a 3-slot ROM multiplexer. It converts a client address into an SDRAM word address plus offset and raises `req` on a cache miss. It captures the 32-bit line returned by the SDRAM controller and serves 8-, 16- or 32-bit data from that line.

## Interface
- `SDRAMW`, 22, SDRAM word-address width.
- `AW`, 18, client address width.
- `DW`, 8, client data width: 8, 16 or 32.
- `LATCH`, 0, 1 = register `dout`/`data_ok` (one extra cycle).
- `DOUBLE`, 0, 1 = two cache lines instead of one.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clr` in 1: synchronous cache invalidate.
- `offset` in SDRAMW: region base, in 16-bit words.
- `addr` in AW: client address, in units of DW.
- `addr_ok` in 1: client request valid (chip select).
- `sdram_addr` out SDRAMW: line address presented to the arbiter.
- `din` in 16: SDRAM read data.
- `din_ok` in 1: second (last) word valid; read complete.
- `dst` in 1: first word of the burst valid.
- `dout` out DW: client data.
- `req` out 1: miss, fetch needed.
- `data_ok` out 1: `dout` valid for the current `addr`.
- `we` in 1: arbiter grant; this slot owns the current SDRAM transfer.

## Operation
- **Line.** A line is 32 bits, i.e. two consecutive 16-bit SDRAM words.
- **Line address.** `line = addr >> 2` (DW=8), `addr >> 1` (DW=16), `addr` (DW=32).
- **Sub-address** within the line: `addr[1:0]` (DW=8), `addr[0]` (DW=16), none (DW=32).
- **SDRAM address.** `sdram_addr = offset + {line, 1'b0}`, truncated to SDRAMW bits, combinational from `addr`. Every fetch is even-aligned.
- **Cache contents.** Each entry has a valid bit, a line tag and 32-bit data.
  - DOUBLE=0: one entry.
  - DOUBLE=1: two entries. On fill, the new line goes to entry 0 and the old entry 0 moves to entry 1.
- **Hit.** `hit = addr_ok & valid & (tag == line)`, for any entry. On a hit, `dout` = selected byte/half/word of the line (lowest sub-address = least significant bits).
- **Request.** `req = addr_ok & ~hit & ~we`. The arbiter latches `sdram_addr` when it accepts `req`.
- **Fill sequence:**
  - On the first cycle of `we`, latch `line` as the pending tag.
  - With `we=1`, `dst=1`: store `din` as line bits [15:0].
  - With `we=1`, `din_ok=1`: store `din` as bits [31:16], write the pending tag, set valid.
  - `dst`/`din_ok` with `we=0` are ignored.
- **Address changes** during a fetch do not corrupt the fill; the line is tagged with the pending tag. The client sees a miss until its own line is cached.
- **`clr`** clears all valid bits. If a fill is in flight, it completes but is discarded: valid is not set for a fill begun before `clr`.

## Timing
- **Reset values:** `req`=0, `data_ok`=0, `dout`=0, all valid bits 0, pending tag 0. `sdram_addr` follows `offset` + `addr` combinationally.
- **LATCH=0:** `data_ok`/`dout` are combinational; a hit returns data in the same cycle as `addr_ok`.
- **LATCH=1:** `data_ok`/`dout` are registered. They are valid one cycle after the hit and drop the cycle after `addr_ok` falls or `addr` changes line.
- **Miss latency:**
  - `req` rises combinationally in the cycle `addr_ok` is set.
  - The entry is written on the `din_ok` edge.
  - `data_ok` rises the next cycle (LATCH=0) or two cycles after (LATCH=1).
- **`addr_ok`=0:** `req`=0 and `data_ok`=0 regardless of cache state.
- **Simultaneous `dst` and `din_ok`:** both halves are written from the same `din`. The controller must not do this; it is legal but undefined data.
- **Reset mid-fill:** everything returns to reset values; the pending fill is lost.

## Configuration
- `JTFRAME_ROMRQ_CHECK_EN` defined: simulation-only checks.
  - `$display` plus `$finish` if `din_ok` arrives with `we=1` and no `dst` since `we` rose.
  - Same if `we` falls before `din_ok`.
- Undefined: no checking logic; synthesized behaviour is identical.

## Test plan
- Reset, DW=8, offset=0x100, `addr`=0x0A, `addr_ok`=1 → `sdram_addr`=0x104, `req`=1, `data_ok`=0.
- Grant `we`, then `dst` with `din`=0x3412, then `din_ok` with `din`=0x7856 → next cycle `req`=0, `data_ok`=1, `dout`=0x56. `addr`=0x08 → `dout`=0x12 with no new `req`.
- DW=16, LATCH=1, cached line 0x78563412, `addr` sub-word 1 → `dout`=0x7856 one cycle after `addr_ok`.
- DOUBLE=1: fill line A, then line B, then return to A → hit, no `req`. Fill line C, then return to A → miss.
- Pulse `clr` after a fill, same `addr` → `data_ok`=0, `req`=1.
- Change `addr` to another line between `we` rising and `din_ok` → the stored tag is the original line, and the new address still misses.

Source files
------------

// File: rtl/jtframe_rom_rq_if.sv
// Bundle between the ROM request slot, its client and the SDRAM slot arbiter.
// The slave modport is the slot; the master modport is the client/arbiter side.
interface jtframe_rom_rq_if #(
    parameter int SDRAMW = 22,
    parameter int AW     = 18,
    parameter int DW     = 8
);
    logic              clr;
    logic [SDRAMW-1:0] offset;
    logic [AW-1:0]     addr;
    logic              addr_ok;
    logic [SDRAMW-1:0] sdram_addr;
    logic [15:0]       din;
    logic              din_ok;
    logic              dst;
    logic [DW-1:0]     dout;
    logic              req;
    logic              data_ok;
    logic              we;

    modport slave (
        input  clr, offset, addr, addr_ok, din, din_ok, dst, we,
        output sdram_addr, dout, req, data_ok
    );

    modport master (
        output clr, offset, addr, addr_ok, din, din_ok, dst, we,
        input  sdram_addr, dout, req, data_ok
    );
endinterface

// File: rtl/jtframe_rom_rq.sv
// Read-only SDRAM request slot with a one- or two-line 32-bit cache.
// Define JTFRAME_ROMRQ_CHECK_EN to enable simulation-only handshake checks.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no grant; slot not involved in an SDRAM transfer
// ST_FILL | we=1; slot owns the transfer, filling a line
module jtframe_rom_rq #(
    parameter int SDRAMW = 22,
    parameter int AW     = 18,
    parameter int DW     = 8,
    parameter int LATCH  = 0,
    parameter int DOUBLE = 0
)(
    input  logic            clk,
    input  logic            rst,
    jtframe_rom_rq_if.slave bus
);
    localparam int SW = (DW == 8) ? 2 : (DW == 16) ? 1 : 0;

    typedef enum logic { ST_IDLE, ST_FILL } state_t;

    state_t        state_q, state_d;
    logic          valid0_q, valid0_d, valid1_q, valid1_d;
    logic [AW-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
    logic [31:0]   data0_q, data0_d, data1_q, data1_d;
    logic [15:0]   lo_q, lo_d;
    logic [AW-1:0] pend_q, pend_d;
    logic          discard_q, discard_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          data_ok_q, data_ok_d;

    logic [AW-1:0] line;
    logic [1:0]    sub;
    logic [4:0]    shamt;
    logic          we_rise;
    logic          discard_now;
    logic [AW-1:0] tag_use;
    logic [15:0]   lo_use;
    logic          hit0, hit1, hit;
    logic [31:0]   hit_line, sel;

    always_comb begin
        line  = bus.addr >> SW;
        sub   = 2'd0;
        shamt = 5'd0;
        if (DW == 8) begin
            sub   = bus.addr[1:0];
            shamt = {sub, 3'b000};
        end else if (DW == 16) begin
            sub   = {1'b0, bus.addr[0]};
            shamt = {sub[0], 4'b0000};
        end
    end

    assign bus.sdram_addr = bus.offset + SDRAMW'({line, 1'b0});

    always_comb begin
        hit0      = bus.addr_ok & valid0_q & (tag0_q == line);
        hit1      = (DOUBLE != 0) & bus.addr_ok & valid1_q & (tag1_q == line);
        hit       = hit0 | hit1;
        hit_line  = hit0 ? data0_q : data1_q;
        sel       = hit_line >> shamt;
        dout_d    = hit ? sel[DW-1:0] : dout_q;
        data_ok_d = hit;
        bus.req   = bus.addr_ok & ~hit & ~bus.we;
        if (LATCH != 0) begin
            bus.dout    = dout_q;
            bus.data_ok = data_ok_q;
        end else begin
            bus.dout    = hit ? sel[DW-1:0] : '0;
            bus.data_ok = hit;
        end
    end

    always_comb begin
        state_d   = bus.we ? ST_FILL : ST_IDLE;
        valid0_d  = valid0_q;
        valid1_d  = valid1_q;
        tag0_d    = tag0_q;
        tag1_d    = tag1_q;
        data0_d   = data0_q;
        data1_d   = data1_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        discard_d = discard_q;

        we_rise     = bus.we & (state_q == ST_IDLE);
        discard_now = we_rise ? 1'b0 : discard_q;
        tag_use     = we_rise ? line : pend_q;
        lo_use      = (bus.we & bus.dst) ? bus.din : lo_q;

        if (we_rise) begin
            pend_d    = line;
            discard_d = 1'b0;
        end
        if (bus.we & bus.dst)
            lo_d = bus.din;
        // the new line always lands in entry 0; the previous entry 0 ages into entry 1
        if (bus.we & bus.din_ok & ~discard_now) begin
            if (DOUBLE != 0) begin
                valid1_d = valid0_q;
                tag1_d   = tag0_q;
                data1_d  = data0_q;
            end
            valid0_d = 1'b1;
            tag0_d   = tag_use;
            data0_d  = {bus.din, lo_use};
        end
        // a fill in flight when clr arrives finishes but must not revive the line
        if (bus.clr) begin
            valid0_d = 1'b0;
            valid1_d = 1'b0;
            if (bus.we)
                discard_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            valid0_q  <= 1'b0;
            valid1_q  <= 1'b0;
            tag0_q    <= '0;
            tag1_q    <= '0;
            data0_q   <= '0;
            data1_q   <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            discard_q <= 1'b0;
            dout_q    <= '0;
            data_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid0_q  <= valid0_d;
            valid1_q  <= valid1_d;
            tag0_q    <= tag0_d;
            tag1_q    <= tag1_d;
            data0_q   <= data0_d;
            data1_q   <= data1_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            discard_q <= discard_d;
            dout_q    <= dout_d;
            data_ok_q <= data_ok_d;
        end
    end

`ifdef JTFRAME_ROMRQ_CHECK_EN
    logic dst_seen_q;
    logic done_q;
    logic dst_seen_now;

    assign dst_seen_now = bus.dst | (dst_seen_q & ~we_rise);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_seen_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (bus.we) begin
                dst_seen_q <= dst_seen_now;
                done_q     <= bus.din_ok | (done_q & ~we_rise);
            end
            if (bus.we & bus.din_ok & ~dst_seen_now) begin
                $display("jtframe_rom_rq: din_ok without dst since we rose");
                $finish;
            end
            if ((state_q == ST_FILL) & ~bus.we & ~done_q) begin
                $display("jtframe_rom_rq: we dropped before din_ok");
                $finish;
            end
        end
    end
`else
    // handshake checks compiled out
`endif

endmodule

// File: tb/tb_jtframe_rom_rq.sv
// Bench for jtframe_rom_rq: three configurations (byte/one line, half/latched, byte/two lines)
// checked with directed steps and a randomized phase against a ROM-content model.
module tb_jtframe_rom_rq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [17:0] addr_a  [3];
    logic        aok_a   [3];
    logic        we_a    [3];
    logic        dst_a   [3];
    logic        dinok_a [3];
    logic        clr_a   [3];
    logic [15:0] din_a   [3];
    logic [21:0] off_a   [3];
    logic [21:0] sa_a    [3];
    logic        req_a   [3];
    logic        dok_a   [3];
    logic [31:0] dout_a  [3];

    jtframe_rom_rq_if #(.SDRAMW(22), .AW(18), .DW(8))  b0();
    jtframe_rom_rq_if #(.SDRAMW(22), .AW(18), .DW(16)) b1();
    jtframe_rom_rq_if #(.SDRAMW(22), .AW(18), .DW(8))  b2();

    jtframe_rom_rq #(.SDRAMW(22), .AW(18), .DW(8),  .LATCH(0), .DOUBLE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    jtframe_rom_rq #(.SDRAMW(22), .AW(18), .DW(16), .LATCH(1), .DOUBLE(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
    jtframe_rom_rq #(.SDRAMW(22), .AW(18), .DW(8),  .LATCH(0), .DOUBLE(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

    assign b0.addr = addr_a[0]; assign b0.addr_ok = aok_a[0]; assign b0.we = we_a[0]; assign b0.dst = dst_a[0];
    assign b0.din_ok = dinok_a[0]; assign b0.clr = clr_a[0]; assign b0.din = din_a[0]; assign b0.offset = off_a[0];
    assign b1.addr = addr_a[1]; assign b1.addr_ok = aok_a[1]; assign b1.we = we_a[1]; assign b1.dst = dst_a[1];
    assign b1.din_ok = dinok_a[1]; assign b1.clr = clr_a[1]; assign b1.din = din_a[1]; assign b1.offset = off_a[1];
    assign b2.addr = addr_a[2]; assign b2.addr_ok = aok_a[2]; assign b2.we = we_a[2]; assign b2.dst = dst_a[2];
    assign b2.din_ok = dinok_a[2]; assign b2.clr = clr_a[2]; assign b2.din = din_a[2]; assign b2.offset = off_a[2];

    assign sa_a[0] = b0.sdram_addr; assign req_a[0] = b0.req; assign dok_a[0] = b0.data_ok; assign dout_a[0] = {24'd0, b0.dout};
    assign sa_a[1] = b1.sdram_addr; assign req_a[1] = b1.req; assign dok_a[1] = b1.data_ok; assign dout_a[1] = {16'd0, b1.dout};
    assign sa_a[2] = b2.sdram_addr; assign req_a[2] = b2.req; assign dok_a[2] = b2.data_ok; assign dout_a[2] = {24'd0, b2.dout};

    // model: lines fetched since the last clr, most recent first
    int rec  [3][2];
    int nrec [3];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    function automatic int line_of(input int k, input logic [17:0] a);
        return (k == 1) ? int'(a / 18'd2) : int'(a / 18'd4);
    endfunction

    function automatic logic [21:0] sa_of(input int k, input logic [17:0] a);
        logic [31:0] s;
        s = 32'(off_a[k]) + 32'(2 * line_of(k, a));
        return s[21:0];
    endfunction

    function automatic logic [15:0] romw(input logic [21:0] w);
        logic [31:0] x;
        x = 32'(w) * 32'd40503 + 32'd12345;
        return x[15:0];
    endfunction

    function automatic logic [31:0] exp_dout(input int k, input logic [17:0] a);
        logic [21:0] sa;
        logic [31:0] data, v;
        int sub, dw;
        sa   = sa_of(k, a);
        data = {romw(sa + 22'd1), romw(sa)};
        dw   = (k == 1) ? 16 : 8;
        sub  = (k == 1) ? int'(a % 18'd2) : int'(a % 18'd4);
        v    = data >> (sub * dw);
        return (dw == 16) ? {16'd0, v[15:0]} : {24'd0, v[7:0]};
    endfunction

    function automatic bit mhit(input int k, input logic [17:0] a);
        for (int i = 0; i < nrec[k]; i++)
            if (rec[k][i] == line_of(k, a)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mpush(input int k, input int l);
        if (k == 2) begin
            rec[k][1] = rec[k][0];
            nrec[k]   = (nrec[k] < 2) ? nrec[k] + 1 : 2;
        end else begin
            nrec[k] = 1;
        end
        rec[k][0] = l;
    endtask

    task automatic fill(input int k, input logic [15:0] lo, input logic [15:0] hi,
                        input logic [17:0] chg_addr, input bit chg);
        tick; we_a[k] = 1'b1;
        tick; dst_a[k] = 1'b1; din_a[k] = lo;
        if (chg) addr_a[k] = chg_addr;
        tick; dst_a[k] = 1'b0; dinok_a[k] = 1'b1; din_a[k] = hi;
        tick; dinok_a[k] = 1'b0; we_a[k] = 1'b0;
    endtask

    task automatic miss_fill(input int k, input logic [17:0] a);
        logic [21:0] sa;
        sa = sa_of(k, a);
        fill(k, romw(sa), romw(sa + 22'd1), 18'd0, 1'b0);
        mpush(k, line_of(k, a));
    endtask

    task automatic do_clr(input int k);
        tick; clr_a[k] = 1'b1;
        tick; clr_a[k] = 1'b0;
        nrec[k] = 0;
    endtask

    task automatic step(input int k, input logic [17:0] a);
        bit h;
        tick; addr_a[k] = a; aok_a[k] = 1'b1;
        settle;
        h = mhit(k, a);
        chkb("req", req_a[k], !h);
        chkw("sdram_addr", 32'(sa_a[k]), 32'(sa_of(k, a)));
        if (k == 1) begin tick; settle; end
        chkb("data_ok", dok_a[k], h);
        if (h) chkw("dout_hit", dout_a[k], exp_dout(k, a));
        else begin
            miss_fill(k, a);
            settle;
            if (k == 1) begin tick; settle; end
            chkb("fill_data_ok", dok_a[k], 1'b1);
            chkb("fill_req", req_a[k], 1'b0);
            chkw("fill_dout", dout_a[k], exp_dout(k, a));
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr_a[k] = '0; aok_a[k] = 1'b0; we_a[k] = 1'b0; dst_a[k] = 1'b0;
            dinok_a[k] = 1'b0; clr_a[k] = 1'b0; din_a[k] = '0; off_a[k] = '0;
            nrec[k] = 0; rec[k][0] = 0; rec[k][1] = 0;
        end
        repeat (3) @(posedge clk);
        settle;
        for (int k = 0; k < 3; k++) begin
            chkb("rst_req", req_a[k], 1'b0);
            chkb("rst_data_ok", dok_a[k], 1'b0);
            chkw("rst_dout", dout_a[k], 32'd0);
        end
        tick; rst = 1'b0;

        // byte slot, single line
        tick; off_a[0] = 22'h100; addr_a[0] = 18'h0A; aok_a[0] = 1'b1;
        settle;
        chkw("d0_sdram_addr", 32'(sa_a[0]), 32'h104);
        chkb("d0_req", req_a[0], 1'b1);
        chkb("d0_data_ok", dok_a[0], 1'b0);
        fill(0, 16'h3412, 16'h7856, 18'd0, 1'b0);
        settle;
        chkb("d0_fill_req", req_a[0], 1'b0);
        chkb("d0_fill_ok", dok_a[0], 1'b1);
        chkw("d0_fill_dout", dout_a[0], 32'h56);
        tick; addr_a[0] = 18'h08;
        settle;
        chkw("d0_sub0_dout", dout_a[0], 32'h12);
        chkb("d0_sub0_req", req_a[0], 1'b0);
        do_clr(0);
        settle;
        chkb("d0_clr_ok", dok_a[0], 1'b0);
        chkb("d0_clr_req", req_a[0], 1'b1);
        fill(0, 16'h3412, 16'h7856, 18'h20, 1'b1);
        settle;
        chkb("d0_chg_req", req_a[0], 1'b1);
        chkb("d0_chg_ok", dok_a[0], 1'b0);
        chkw("d0_chg_sa", 32'(sa_a[0]), 32'h110);
        tick; addr_a[0] = 18'h0B;
        settle;
        chkb("d0_orig_ok", dok_a[0], 1'b1);
        chkw("d0_orig_dout", dout_a[0], 32'h78);
        tick; addr_a[0] = 18'h40;
        tick; we_a[0] = 1'b1;
        tick; dst_a[0] = 1'b1; din_a[0] = 16'h1111; clr_a[0] = 1'b1;
        tick; clr_a[0] = 1'b0; dst_a[0] = 1'b0; dinok_a[0] = 1'b1; din_a[0] = 16'h2222;
        tick; dinok_a[0] = 1'b0; we_a[0] = 1'b0;
        settle;
        chkb("d0_clrfill_ok", dok_a[0], 1'b0);
        chkb("d0_clrfill_req", req_a[0], 1'b1);
        tick; addr_a[0] = 18'h0A;
        settle;
        chkb("d0_clr_old_ok", dok_a[0], 1'b0);
        tick; we_a[0] = 1'b1;
        tick; dst_a[0] = 1'b1; din_a[0] = 16'hAAAA;
        tick; dst_a[0] = 1'b0; we_a[0] = 1'b0; rst = 1'b1;
        tick; rst = 1'b0;
        settle;
        chkb("d0_rstfill_req", req_a[0], 1'b1);
        chkb("d0_rstfill_ok", dok_a[0], 1'b0);

        // half-word slot, registered output
        tick; off_a[1] = 22'h0; addr_a[1] = 18'h3; aok_a[1] = 1'b1;
        settle;
        chkw("d1_sa", 32'(sa_a[1]), 32'h2);
        chkb("d1_req", req_a[1], 1'b1);
        fill(1, 16'h3412, 16'h7856, 18'd0, 1'b0);
        settle;
        chkb("d1_ok_lag", dok_a[1], 1'b0);
        tick; settle;
        chkb("d1_ok", dok_a[1], 1'b1);
        chkw("d1_dout", dout_a[1], 32'h7856);
        tick; aok_a[1] = 1'b0;
        settle;
        chkb("d1_off_req", req_a[1], 1'b0);
        chkb("d1_off_ok_hold", dok_a[1], 1'b1);
        tick; settle;
        chkb("d1_off_ok", dok_a[1], 1'b0);
        tick; aok_a[1] = 1'b1; addr_a[1] = 18'h2;
        settle;
        chkb("d1_on_ok_lag", dok_a[1], 1'b0);
        chkb("d1_on_req", req_a[1], 1'b0);
        tick; settle;
        chkb("d1_on_ok", dok_a[1], 1'b1);
        chkw("d1_on_dout", dout_a[1], 32'h3412);

        // two-line cache: A, B, A hits, C evicts A
        tick; off_a[2] = 22'h40;
        step(2, 18'h00);
        step(2, 18'h10);
        step(2, 18'h03);
        step(2, 18'h20);
        step(2, 18'h11);
        tick; addr_a[2] = 18'h01;
        settle;
        chkb("d2_evict_req", req_a[2], 1'b1);
        chkb("d2_evict_ok", dok_a[2], 1'b0);

        // randomized phase against the model
        for (int k = 0; k < 3; k++) begin
            tick; off_a[k] = 22'($urandom);
            do_clr(k);
            for (int n = 0; n < 30; n++) begin
                if ($urandom_range(0, 7) == 0) do_clr(k);
                if ($urandom_range(0, 5) == 0) begin
                    tick; aok_a[k] = 1'b0;
                    settle;
                    chkb("rnd_idle_req", req_a[k], 1'b0);
                    if (k == 1) begin tick; settle; end
                    chkb("rnd_idle_ok", dok_a[k], 1'b0);
                end
                step(k, 18'($urandom_range(0, 47)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
